// File: rtl/tcp_tx_hs_pkg.sv
// rtl/tcp_tx_hs_pkg.sv - shared types and field layout for tcp_tx_handshake
package tcp_tx_hs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        META,
        WAIT_STATUS,
        SEND,
        DRAIN,
        BACKOFF
    } hs_state_t;

    localparam logic [1:0] TX_OK      = 2'd0;
    localparam logic [1:0] TX_NOCONN  = 2'd1;
    localparam logic [1:0] TX_NOSPACE = 2'd2;

    localparam int STAT_SESSION_LSB = 0;
    localparam int STAT_SESSION_W   = 16;
    localparam int STAT_ERR_LSB     = 62;
    localparam int STAT_ERR_W       = 2;

    localparam int META_SESSION_W = 16;
    localparam int META_LEN_W     = 16;

endpackage

// File: rtl/tcp_tx_handshake.sv
// rtl/tcp_tx_handshake.sv - one-session-in-flight TX metadata/status/payload handshake; retry/backoff under TCP_TX_HS_RETRY_EN
module tcp_tx_handshake
    import tcp_tx_hs_pkg::*;
#(
    parameter int PKT_LEN_BYTES = 64,
    parameter int RETRY_WAIT    = 256,
    parameter int MAX_RETRIES   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_meta_valid,
    output logic         s_meta_ready,
    input  logic [15:0]  s_meta_data,
    input  logic         s_data_valid,
    output logic         s_data_ready,
    input  logic [511:0] s_data_data,
    input  logic         s_data_last,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST,
    output logic [31:0]  sent_count,
    output logic [31:0]  dropped_count
);

    hs_state_t state_q, state_d;

    logic [31:0]               meta_tdata_q;
    logic                      meta_ready_q;
    logic [31:0]               sent_q;
    logic [31:0]               dropped_q;
    logic [META_LEN_W-1:0]     pkt_len;
    logic [STAT_SESSION_W-1:0] st_session;
    logic [STAT_ERR_W-1:0]     st_err;
    logic                      status_match;
    logic                      meta_load;
    logic                      send_done;
    logic                      drain_done;
    logic                      unused_status;

    assign pkt_len      = META_LEN_W'(PKT_LEN_BYTES);
    assign st_session   = s_axis_tx_status_TDATA[STAT_SESSION_LSB +: STAT_SESSION_W];
    assign st_err       = s_axis_tx_status_TDATA[STAT_ERR_LSB +: STAT_ERR_W];
    // The latched session lives in the low half of the held metadata word.
    assign status_match = s_axis_tx_status_TVALID &&
                          (st_session == meta_tdata_q[META_SESSION_W-1:0]);
    assign meta_load    = (state_q == IDLE) && (state_d == META);
    assign unused_status = ^s_axis_tx_status_TDATA[STAT_ERR_LSB-1:STAT_SESSION_LSB+STAT_SESSION_W];

`ifdef TCP_TX_HS_RETRY_EN
    localparam int BO_W = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [BO_W-1:0] bo_cnt_q;
    logic [RT_W-1:0] retry_q;
    logic            bo_done;
    logic            retry_ok;

    assign retry_ok = (retry_q < RT_W'(MAX_RETRIES));
    assign bo_done  = (bo_cnt_q == BO_W'(RETRY_WAIT - 1));
`else
    logic unused_params;
    assign unused_params = ^{RETRY_WAIT, MAX_RETRIES};
`endif

    // Next-state and handshake decode; only WAIT_STATUS accepts status, only SEND/DRAIN touch payload.
    always_comb begin
        state_d                 = state_q;
        s_axis_tx_status_TREADY = 1'b0;
        m_axis_tx_data_TVALID   = 1'b0;
        s_data_ready            = 1'b0;
        send_done               = 1'b0;
        drain_done              = 1'b0;
        case (state_q)
            IDLE: begin
                // While the completion pulse is out the queue head is still the finished session.
                if (s_meta_valid && !meta_ready_q) begin
                    state_d = META;
                end
            end
            META: begin
                if (m_axis_tx_metadata_TREADY) begin
                    state_d = WAIT_STATUS;
                end
            end
            WAIT_STATUS: begin
                s_axis_tx_status_TREADY = 1'b1;
                if (status_match) begin
                    case (st_err)
                        TX_OK:     state_d = SEND;
                        TX_NOCONN: state_d = DRAIN;
`ifdef TCP_TX_HS_RETRY_EN
                        TX_NOSPACE: state_d = retry_ok ? BACKOFF : DRAIN;
`else
                        TX_NOSPACE: state_d = DRAIN;
`endif
                        default:   state_d = DRAIN;
                    endcase
                end
            end
            SEND: begin
                m_axis_tx_data_TVALID = s_data_valid;
                s_data_ready          = m_axis_tx_data_TREADY;
                if (s_data_valid && m_axis_tx_data_TREADY && s_data_last) begin
                    send_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                s_data_ready = 1'b1;
                if (s_data_valid && s_data_last) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
`ifdef TCP_TX_HS_RETRY_EN
            BACKOFF: begin
                if (bo_done) begin
                    state_d = META;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Metadata word is captured once per session and reused unchanged on retries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_tdata_q <= '0;
        end else if (meta_load) begin
            meta_tdata_q <= {pkt_len, s_meta_data};
        end
    end

    // Session completion: pop the session queue one cycle later and count the outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_ready_q <= 1'b0;
            sent_q       <= '0;
            dropped_q    <= '0;
        end else begin
            meta_ready_q <= send_done || drain_done;
            if (send_done) begin
                sent_q <= sent_q + 32'd1;
            end
            if (drain_done) begin
                dropped_q <= dropped_q + 32'd1;
            end
        end
    end

`ifdef TCP_TX_HS_RETRY_EN
    // Backoff timer runs only in BACKOFF; retry count restarts with each new session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bo_cnt_q <= '0;
            retry_q  <= '0;
        end else begin
            if (state_q == BACKOFF) begin
                bo_cnt_q <= bo_cnt_q + BO_W'(1);
            end else begin
                bo_cnt_q <= '0;
            end
            if (meta_load) begin
                retry_q <= '0;
            end else if ((state_q == BACKOFF) && bo_done) begin
                retry_q <= retry_q + RT_W'(1);
            end
        end
    end
`endif

    assign s_meta_ready              = meta_ready_q;
    assign m_axis_tx_metadata_TVALID = (state_q == META);
    assign m_axis_tx_metadata_TDATA  = meta_tdata_q;
    assign m_axis_tx_data_TDATA      = (state_q == SEND) ? s_data_data : '0;
    assign m_axis_tx_data_TLAST      = (state_q == SEND) && s_data_last;
    assign m_axis_tx_data_TKEEP      = '1;
    assign sent_count                = sent_q;
    assign dropped_count             = dropped_q;

endmodule

// File: tb/tb_tcp_tx_handshake.sv
// tb/tb_tcp_tx_handshake.sv - randomized self-checking bench for tcp_tx_handshake
module tb_tcp_tx_handshake;

    localparam int PKT_LEN = 64;
    localparam int RW      = 4;
    localparam int MR      = 2;
`ifdef TCP_TX_HS_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_meta_valid;
    logic         s_meta_ready;
    logic [15:0]  s_meta_data;
    logic         s_data_valid;
    logic         s_data_ready;
    logic [511:0] s_data_data;
    logic         s_data_last;
    logic         m_axis_tx_metadata_TVALID;
    logic         m_axis_tx_metadata_TREADY;
    logic [31:0]  m_axis_tx_metadata_TDATA;
    logic         s_axis_tx_status_TVALID;
    logic         s_axis_tx_status_TREADY;
    logic [63:0]  s_axis_tx_status_TDATA;
    logic         m_axis_tx_data_TVALID;
    logic         m_axis_tx_data_TREADY;
    logic [511:0] m_axis_tx_data_TDATA;
    logic [63:0]  m_axis_tx_data_TKEEP;
    logic         m_axis_tx_data_TLAST;
    logic [31:0]  sent_count;
    logic [31:0]  dropped_count;

    always #5 clk = ~clk;

    tcp_tx_handshake #(
        .PKT_LEN_BYTES(PKT_LEN),
        .RETRY_WAIT(RW),
        .MAX_RETRIES(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_meta_valid(s_meta_valid),
        .s_meta_ready(s_meta_ready),
        .s_meta_data(s_meta_data),
        .s_data_valid(s_data_valid),
        .s_data_ready(s_data_ready),
        .s_data_data(s_data_data),
        .s_data_last(s_data_last),
        .m_axis_tx_metadata_TVALID(m_axis_tx_metadata_TVALID),
        .m_axis_tx_metadata_TREADY(m_axis_tx_metadata_TREADY),
        .m_axis_tx_metadata_TDATA(m_axis_tx_metadata_TDATA),
        .s_axis_tx_status_TVALID(s_axis_tx_status_TVALID),
        .s_axis_tx_status_TREADY(s_axis_tx_status_TREADY),
        .s_axis_tx_status_TDATA(s_axis_tx_status_TDATA),
        .m_axis_tx_data_TVALID(m_axis_tx_data_TVALID),
        .m_axis_tx_data_TREADY(m_axis_tx_data_TREADY),
        .m_axis_tx_data_TDATA(m_axis_tx_data_TDATA),
        .m_axis_tx_data_TKEEP(m_axis_tx_data_TKEEP),
        .m_axis_tx_data_TLAST(m_axis_tx_data_TLAST),
        .sent_count(sent_count),
        .dropped_count(dropped_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Current session scenario
    logic [15:0]  sc_sid;
    logic [511:0] sc_words[$];
    int           sc_errs[$];
    int           sc_mism;
    logic [15:0]  sc_fixed_mism;
    bit           sc_toggle;
    bit           sc_abort;

    int exp_sent_total = 0;
    int exp_drop_total = 0;

    task automatic drive_idle();
        s_meta_valid              = 1'b0;
        s_meta_data               = '0;
        s_data_valid              = 1'b0;
        s_data_data               = '0;
        s_data_last               = 1'b0;
        s_axis_tx_status_TVALID   = 1'b0;
        s_axis_tx_status_TDATA    = '0;
        m_axis_tx_metadata_TREADY = 1'b0;
        m_axis_tx_data_TREADY     = 1'b0;
    endtask

    task automatic gap(input int k);
        drive_idle();
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_sent_total = 0;
        exp_drop_total = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic new_sc(input logic [15:0] sid, input int n, input int mism);
        logic [511:0] w;
        sc_sid        = sid;
        sc_mism       = mism;
        sc_fixed_mism = 16'h0;
        sc_toggle     = 1'b0;
        sc_abort      = 1'b0;
        sc_words.delete();
        sc_errs.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
            sc_words.push_back(w);
        end
    endtask

    function automatic logic [63:0] mk_status(input logic [15:0] sess, input int e);
        logic [1:0] ev;
        ev = 2'(e);
        return {ev, 46'd0, sess};
    endfunction

    task automatic run_session();
        int n, attempts, k, e, d_idx, s_idx, beats, pulses, meta_hs, finals;
        int retry_cyc, ok_cyc, done_cyc, c, nm;
        bit sent, meta_pend, fin, prev_tv, aborted;
        logic [63:0] st_stream[$];
        bit          st_final[$];
        bit          st_retry[$];

        // Reference outcome: walk the status error codes session-level, one request per attempt.
        n = sc_words.size();
        attempts = 0;
        sent = 1'b0;
        fin = 1'b0;
        k = 0;
        while (!fin) begin
            e = (k < sc_errs.size()) ? sc_errs[k] : 0;
            attempts++;
            if (k == 0 && sc_fixed_mism != 16'h0) begin
                st_stream.push_back(mk_status(sc_fixed_mism, 0));
                st_final.push_back(1'b0);
                st_retry.push_back(1'b0);
            end
            nm = $urandom_range(0, sc_mism);
            for (int m = 0; m < nm; m++) begin
                st_stream.push_back(mk_status(sc_sid ^ 16'($urandom_range(1, 65535)), $urandom_range(0, 3)));
                st_final.push_back(1'b0);
                st_retry.push_back(1'b0);
            end
            st_stream.push_back(mk_status(sc_sid, e));
            st_final.push_back(1'b1);
            if (e == 0) begin
                sent = 1'b1;
                fin = 1'b1;
                st_retry.push_back(1'b0);
            end else if (e == 2 && RETRY_EN && (attempts - 1) < MR) begin
                st_retry.push_back(1'b1);
            end else begin
                fin = 1'b1;
                st_retry.push_back(1'b0);
            end
            k++;
        end

        meta_pend = 1'b1;
        d_idx = 0; s_idx = 0; beats = 0; pulses = 0; meta_hs = 0; finals = 0;
        retry_cyc = -100; ok_cyc = -100; done_cyc = -1;
        prev_tv = 1'b0; aborted = 1'b0;

        for (c = 0; c < 3000; c++) begin
            s_meta_valid = meta_pend;
            s_meta_data  = meta_pend ? sc_sid : 16'h0;
            if (sc_toggle) s_data_valid = (d_idx < n);
            else           s_data_valid = (d_idx < n) && ($urandom_range(0, 3) != 0);
            s_data_data  = (d_idx < n) ? sc_words[d_idx] : '0;
            s_data_last  = (d_idx == n - 1);
            // Statuses are offered from the start of the session so back-pressure is exercised.
            s_axis_tx_status_TVALID = (s_idx < st_stream.size()) && ($urandom_range(0, 2) != 0);
            s_axis_tx_status_TDATA  = (s_idx < st_stream.size()) ? st_stream[s_idx] : '0;
            m_axis_tx_metadata_TREADY = ($urandom_range(0, 2) != 0);
            m_axis_tx_data_TREADY     = sc_toggle ? (c % 2 == 1) : ($urandom_range(0, 3) != 0);

            @(negedge clk);

            if (sc_abort && m_axis_tx_data_TVALID) begin
                #2 rst = 1'b1;
                #1;
                check("rst_meta_tvalid", m_axis_tx_metadata_TVALID, 0);
                check("rst_meta_tdata", m_axis_tx_metadata_TDATA, 0);
                check("rst_status_tready", s_axis_tx_status_TREADY, 0);
                check("rst_data_tvalid", m_axis_tx_data_TVALID, 0);
                check("rst_data_tdata", m_axis_tx_data_TDATA, 0);
                check("rst_data_tlast", m_axis_tx_data_TLAST, 0);
                check("rst_s_data_ready", s_data_ready, 0);
                check("rst_s_meta_ready", s_meta_ready, 0);
                check("rst_sent", sent_count, 0);
                check("rst_dropped", dropped_count, 0);
                aborted = 1'b1;
                break;
            end

            if (s_axis_tx_status_TVALID && s_axis_tx_status_TREADY) begin
                check("st_in_wait", meta_hs > finals, 1);
                if (st_final[s_idx]) begin
                    finals++;
                    if (st_retry[s_idx]) retry_cyc = c;
                    else if (st_stream[s_idx][63:62] == 2'd0) ok_cyc = c;
                end
                s_idx++;
            end

            if (sent && c == ok_cyc + 1) begin
                check("send_latency", m_axis_tx_data_TVALID, s_data_valid);
            end

            if (m_axis_tx_metadata_TVALID && !prev_tv) begin
                if (meta_hs == 0) check("meta_latency", c, 1);
                // A retry spends RETRY_WAIT whole cycles backing off between status and new request.
                else check("backoff_gap", c - retry_cyc, RW + 1);
            end
            prev_tv = m_axis_tx_metadata_TVALID;
            if (m_axis_tx_metadata_TVALID && m_axis_tx_metadata_TREADY) begin
                check("meta_tdata", m_axis_tx_metadata_TDATA, {16'(PKT_LEN), sc_sid});
                meta_hs++;
            end

            if (m_axis_tx_data_TVALID) begin
                check("drop_no_beats", sent, 1);
            end
            if (m_axis_tx_data_TVALID && m_axis_tx_data_TREADY) begin
                if (beats < n) begin
                    check("beat_data", m_axis_tx_data_TDATA, sc_words[beats]);
                    check("beat_last", m_axis_tx_data_TLAST, beats == n - 1);
                    check("beat_keep", m_axis_tx_data_TKEEP, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("beat_extra", beats + 1, n);
                end
                beats++;
            end

            if (s_data_valid && s_data_ready) d_idx++;
            if (s_meta_ready) pulses++;
            if (s_meta_valid && s_meta_ready) begin
                meta_pend = 1'b0;
                done_cyc = c;
            end

            @(posedge clk);
            #1;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end

        if (aborted) begin
            drive_idle();
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            exp_sent_total = 0;
            exp_drop_total = 0;
            @(posedge clk);
            #1;
            return;
        end

        check("session_done", done_cyc >= 0, 1);
        if (sent) exp_sent_total++;
        else      exp_drop_total++;
        check("meta_requests", meta_hs, attempts);
        check("beats_out", beats, sent ? n : 0);
        check("payload_used", d_idx, n);
        check("status_used", s_idx, st_stream.size());
        check("meta_ready_pulses", pulses, 1);
        check("sent_count", sent_count, exp_sent_total);
        check("dropped_count", dropped_count, exp_drop_total);
        if (done_cyc < 0) pulse_reset();
        gap($urandom_range(1, 3));
    endtask

    initial begin
        int r, ne;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_meta_tvalid", m_axis_tx_metadata_TVALID, 0);
        check("reset_status_tready", s_axis_tx_status_TREADY, 0);
        check("reset_meta_ready", s_meta_ready, 0);
        check("reset_sent", sent_count, 0);
        check("reset_dropped", dropped_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        new_sc(16'h0005, 1, 0); sc_errs = '{0};          run_session();
        new_sc(16'h0005, 2, 0); sc_errs = '{1};          run_session();
        new_sc(16'h0005, 1, 0); sc_errs = '{2, 2, 0};    run_session();
        new_sc(16'h0005, 2, 0); sc_errs = '{0}; sc_fixed_mism = 16'h0009; run_session();
        new_sc(16'h0033, 3, 0); sc_errs = '{0}; sc_toggle = 1'b1;         run_session();
        new_sc(16'h0042, 2, 0); sc_errs = '{2, 2, 2, 2}; run_session();
        new_sc(16'h0043, 1, 0); sc_errs = '{3};          run_session();

        for (int s = 0; s < 40; s++) begin
            new_sc(16'($urandom_range(0, 65535)), $urandom_range(1, 4), $urandom_range(0, 2));
            ne = $urandom_range(1, 3);
            for (int i = 0; i < ne; i++) begin
                r = $urandom_range(0, 9);
                sc_errs.push_back(r < 5 ? 0 : (r < 7 ? 2 : (r < 9 ? 1 : 3)));
            end
            run_session();
        end

        new_sc(16'h0077, 3, 0); sc_errs = '{0}; sc_abort = 1'b1; run_session();
        new_sc(16'h0005, 2, 0); sc_errs = '{0};                  run_session();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
